// File: rtl/tank_gfx_pkg.sv
// tank_gfx_pkg
//   Shared definitions for the sprite line engine.
//   - Bit positions of the fields in a 32-bit OAM word.
//   - The default tile size. The atlas is 8x8 tiles, so each atlas
//     coordinate is clog2(8*TILE) bits wide.
//   - The per-slot storage record and the scan FSM state type.
package tank_gfx_pkg;

    localparam int OAM_EN_BIT  = 28;
    localparam int OAM_X_MSB   = 27;
    localparam int OAM_X_LSB   = 18;
    localparam int OAM_Y_MSB   = 17;
    localparam int OAM_Y_LSB   = 8;
    localparam int OAM_ROW_MSB = 7;
    localparam int OAM_ROW_LSB = 5;
    localparam int OAM_COL_MSB = 4;
    localparam int OAM_COL_LSB = 2;

    localparam int DEF_TILE_W  = 8;
    localparam int DEF_TILE_H  = 8;
    localparam int SPR_COORD_W = $clog2(8 * DEF_TILE_W);

    // One latched sprite for the upcoming line. rom_y already folds in the
    // atlas row and the sprite-relative line offset.
    typedef struct packed {
        logic                   valid;
        logic [9:0]             sx;
        logic [SPR_COORD_W-1:0] rom_y;
        logic [2:0]             col;
    } sprite_slot_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN
    } scan_state_t;

endpackage

// File: rtl/sprite_slot_match.sv
// sprite_slot_match
//   Horizontal hit test and atlas x-coordinate for one sprite slot.
//   Ports:
//     valid  in   slot holds a sprite for this line
//     sx     in   sprite left edge
//     col    in   atlas column of the sprite tile
//     x      in   current pixel x
//     hit    out  valid && sx <= x < sx+TILE_W (11-bit compare, no wrap)
//     rom_x  out  col*TILE_W + (x - sx); meaningful only when hit=1
module sprite_slot_match
    import tank_gfx_pkg::*;
#(
    parameter int TILE_W = DEF_TILE_W,
    parameter int CW     = SPR_COORD_W
) (
    input  logic          valid,
    input  logic [9:0]    sx,
    input  logic [2:0]    col,
    input  logic [9:0]    x,
    output logic          hit,
    output logic [CW-1:0] rom_x
);

    logic [10:0]   x_ext;
    logic [10:0]   sx_ext;
    logic [CW-1:0] dx;

    assign x_ext  = {1'b0, x};
    assign sx_ext = {1'b0, sx};
    assign hit    = valid && (sx_ext <= x_ext) && (x_ext < sx_ext + 11'(TILE_W));

    // On a hit x-sx is below TILE_W, so the low CW bits give the exact offset.
    assign dx    = x[CW-1:0] - sx[CW-1:0];
    assign rom_x = CW'(col) * CW'(TILE_W) + dx;

endmodule

// File: rtl/sprite_line_engine.sv
// sprite_line_engine
//   Per-scanline sprite engine. In hblank it walks all OAM entries and latches
//   up to SLOTS sprites that cross the next line. In active video it picks the
//   lowest-index slot covering x, fetches that pixel from the atlas ROM and
//   emits a colour-keyed pixel three clock edges after x was presented.
//   Ports:
//     clk, reset            pixel clock, asynchronous active-high reset
//     line_start, line_y    hblank pulse and y of the next visible line
//     video_on, x           active-video qualifier and current pixel x
//     oam_addr, oam_rdata   OAM read port (1-cycle synchronous read)
//     rom_addr, rom_data    atlas ROM {rom_y, rom_x}, 1-cycle latency
//     sprite_on, color      opaque sprite pixel and its colour
//     overflow              more than SLOTS sprites hit this line (sticky)
//     scan_busy             a scan is in progress
module sprite_line_engine
    import tank_gfx_pkg::*;
#(
    parameter int          OAM_DEPTH = 16,
    parameter int          SLOTS     = 4,
    parameter int          TILE_W    = DEF_TILE_W,
    parameter int          TILE_H    = DEF_TILE_H,
    parameter logic [11:0] COLOR_KEY = 12'hF0F
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              line_start,
    input  logic [9:0]                        line_y,
    input  logic                              video_on,
    input  logic [9:0]                        x,
    output logic [$clog2(OAM_DEPTH)-1:0]      oam_addr,
    input  logic [31:0]                       oam_rdata,
    output logic [2*$clog2(8*TILE_W)-1:0]     rom_addr,
    input  logic [11:0]                       rom_data,
    output logic                              sprite_on,
    output logic [11:0]                       color,
    output logic                              overflow,
    output logic                              scan_busy
);

    localparam int                OAM_AW   = $clog2(OAM_DEPTH);
    localparam int                CW       = $clog2(8 * TILE_W);
    localparam int                SLOT_IW  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [OAM_AW-1:0] OAM_LAST = OAM_AW'(OAM_DEPTH - 1);

    scan_state_t  state;
    logic [9:0]   line_y_q;
    sprite_slot_t slots [SLOTS];

    // OAM word fields for the entry addressed on the previous cycle.
    logic       ent_en;
    logic [9:0] ent_x;
    logic [9:0] ent_y;
    logic [2:0] ent_row;
    logic [2:0] ent_col;
    logic       unused_oam_bits;

    assign ent_en          = oam_rdata[OAM_EN_BIT];
    assign ent_x           = oam_rdata[OAM_X_MSB:OAM_X_LSB];
    assign ent_y           = oam_rdata[OAM_Y_MSB:OAM_Y_LSB];
    assign ent_row         = oam_rdata[OAM_ROW_MSB:OAM_ROW_LSB];
    assign ent_col         = oam_rdata[OAM_COL_MSB:OAM_COL_LSB];
    assign unused_oam_bits = &{1'b0, oam_rdata[31:29], oam_rdata[1:0]};

    // Vertical accept test, widened to 11 bits so sprites near y=1023 do not
    // wrap around onto the top lines.
    logic [10:0]   ly_ext;
    logic [10:0]   sy_ext;
    logic [CW-1:0] dy;
    logic [CW-1:0] ent_rom_y;
    logic          ent_hit;
    logic          eval_en;

    assign ly_ext    = {1'b0, line_y_q};
    assign sy_ext    = {1'b0, ent_y};
    assign ent_hit   = ent_en && (sy_ext <= ly_ext) && (ly_ext < sy_ext + 11'(TILE_H));
    assign dy        = line_y_q[CW-1:0] - ent_y[CW-1:0];
    assign ent_rom_y = CW'(ent_row) * CW'(TILE_H) + dy;

    // Data is one cycle behind the address: nothing to evaluate on the first
    // SCAN cycle, and DRAIN exists only to evaluate the last entry.
    assign eval_en = ((state == SCAN) && (oam_addr != '0)) || (state == DRAIN);

    // Lowest free slot; slots fill in OAM order so a free slot is always above
    // every occupied one.
    logic               free_found;
    logic [SLOT_IW-1:0] free_idx;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!slots[i].valid) begin
                free_found = 1'b1;
                free_idx   = SLOT_IW'(i);
            end
        end
    end

    // Scan FSM. line_start wins over everything so a late pulse restarts the
    // scan with no partially filled slots left behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            scan_busy <= 1'b0;
            oam_addr  <= '0;
            line_y_q  <= '0;
            overflow  <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                slots[i] <= '0;
            end
        end else if (line_start) begin
            state     <= SCAN;
            scan_busy <= 1'b1;
            oam_addr  <= '0;
            line_y_q  <= line_y;
            overflow  <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                slots[i].valid <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                end
                SCAN: begin
                    if (oam_addr == OAM_LAST) begin
                        state <= DRAIN;
                    end else begin
                        oam_addr <= oam_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    state     <= IDLE;
                    scan_busy <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    scan_busy <= 1'b0;
                end
            endcase

            if (eval_en && ent_hit) begin
                if (free_found) begin
                    slots[free_idx] <= '{valid: 1'b1, sx: ent_x, rom_y: ent_rom_y, col: ent_col};
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // Per-slot horizontal match.
    logic [SLOTS-1:0] slot_hit;
    logic [CW-1:0]    slot_rom_x [SLOTS];

    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        sprite_slot_match #(
            .TILE_W (TILE_W),
            .CW     (CW)
        ) u_match (
            .valid (slots[g].valid),
            .sx    (slots[g].sx),
            .col   (slots[g].col),
            .x     (x),
            .hit   (slot_hit[g]),
            .rom_x (slot_rom_x[g])
        );
    end

    // Fixed priority: lowest slot index wins. Only the winner is fetched, so a
    // transparent winner hides any sprite behind it.
    logic               win_found;
    logic [SLOT_IW-1:0] win_idx;
    logic               pix_gate;
    logic               hit_q;
    logic               hit_d;
    logic               opaque;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (slot_hit[i]) begin
                win_found = 1'b1;
                win_idx   = SLOT_IW'(i);
            end
        end
    end

    // Slots are being rewritten while a scan runs, so pixels are ignored then.
    assign pix_gate = video_on && !scan_busy;
    assign opaque   = hit_d && (rom_data != COLOR_KEY);

    // Three-stage pixel pipeline: address, ROM access, colour key.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_q     <= 1'b0;
            hit_d     <= 1'b0;
            rom_addr  <= '0;
            sprite_on <= 1'b0;
            color     <= 12'h000;
        end else begin
            hit_q <= pix_gate && win_found;
            if (pix_gate && win_found) begin
                rom_addr <= {slots[win_idx].rom_y, slot_rom_x[win_idx]};
            end
            hit_d     <= hit_q;
            sprite_on <= opaque;
            color     <= opaque ? rom_data : 12'h000;
        end
    end

endmodule

// File: tb/tb_sprite_line_engine.sv
// tb_sprite_line_engine
//   Self-checking bench for sprite_line_engine. Models the OAM RAM and atlas
//   ROM, keeps a line-level reference model (list of accepted OAM indices per
//   line, first-covering-sprite per pixel) and compares the DUT against it
//   using fixed tables, hand sequences and randomized lines.
module tb_sprite_line_engine;

    localparam logic [11:0] COLOR_KEY = 12'hF0F;

    logic        clk;
    logic        reset;
    logic        line_start;
    logic [9:0]  line_y;
    logic        video_on;
    logic [9:0]  x;
    logic [3:0]  oam_addr;
    logic [31:0] oam_rdata;
    logic [11:0] rom_addr;
    logic [11:0] rom_data;
    logic        sprite_on;
    logic [11:0] color;
    logic        overflow;
    logic        scan_busy;

    sprite_line_engine dut (
        .clk        (clk),
        .reset      (reset),
        .line_start (line_start),
        .line_y     (line_y),
        .video_on   (video_on),
        .x          (x),
        .oam_addr   (oam_addr),
        .oam_rdata  (oam_rdata),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .sprite_on  (sprite_on),
        .color      (color),
        .overflow   (overflow),
        .scan_busy  (scan_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memories seen by the DUT.
    logic [31:0] oam_mem [16];
    logic        rom_force;
    logic [11:0] rom_force_val;

    function automatic logic [11:0] romFn(logic [11:0] a);
        return a ^ 12'hA5C;
    endfunction

    always @(posedge clk) begin
        oam_rdata <= oam_mem[oam_addr];
        rom_data  <= rom_force ? rom_force_val : romFn(rom_addr);
    end

    int          vectors;
    int          miscompares;
    logic [11:0] exp_rom_addr;

    // Reference model state: accepted OAM indices for the current line.
    int model_list [$];
    bit model_ovf;
    int model_ly;

    function automatic logic [31:0] mkEntry(bit en, int ex, int ey, int row, int col);
        return {3'b000, en, 10'(ex), 10'(ey), 3'(row), 3'(col), 2'b00};
    endfunction

    function automatic void modelScan(int ly);
        logic [31:0] w;
        int sy;
        model_list.delete();
        model_ovf = 1'b0;
        model_ly  = ly;
        for (int k = 0; k < 16; k++) begin
            w  = oam_mem[k];
            sy = int'(w[17:8]);
            if (w[28] && sy <= ly && ly < sy + 8) begin
                if (model_list.size() < 4) model_list.push_back(k);
                else model_ovf = 1'b1;
            end
        end
    endfunction

    function automatic void modelPixel(int px, bit vid, output bit hit, output int addr);
        logic [31:0] w;
        int sx, sy, row, col;
        hit  = 1'b0;
        addr = 0;
        if (!vid) return;
        foreach (model_list[i]) begin
            w   = oam_mem[model_list[i]];
            sx  = int'(w[27:18]);
            sy  = int'(w[17:8]);
            row = int'(w[7:5]);
            col = int'(w[4:2]);
            if (!hit && sx <= px && px < sx + 8) begin
                hit  = 1'b1;
                addr = (row * 8 + (model_ly - sy)) * 64 + col * 8 + (px - sx);
            end
        end
    endfunction

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(int px, bit vid);
        x        = 10'(px);
        video_on = vid;
    endtask

    // Present one pixel, then check rom_addr one edge later and the keyed
    // output three edges later. Called at posedge+1.
    task automatic checkPixel(string name, int px, bit vid, bit hit, logic [11:0] addr);
        logic [11:0] exp_col;
        bit          exp_on;
        if (hit) exp_rom_addr = addr;
        applyStimulus(px, vid);
        @(posedge clk); #1;
        applyStimulus(0, 1'b0);
        checkOutput({name, ".rom_addr"}, 32'(rom_addr), 32'(exp_rom_addr));
        @(posedge clk);
        @(posedge clk); #1;
        exp_col = rom_force ? rom_force_val : romFn(exp_rom_addr);
        exp_on  = hit && (exp_col != COLOR_KEY);
        checkOutput({name, ".sprite_on"}, 32'(sprite_on), 32'(exp_on));
        checkOutput({name, ".color"}, 32'(color), exp_on ? 32'(exp_col) : 32'h0);
    endtask

    task automatic modelCheckPixel(string name, int px, bit vid);
        bit hit;
        int addr;
        modelPixel(px, vid, hit, addr);
        checkPixel(name, px, vid, hit, 12'(addr));
    endtask

    // Pulse line_start, follow the scan to completion (bounded), return the
    // number of busy cycles and optionally check the OAM address sequence.
    task automatic runLine(int ly, bit chk_addr, output int busy);
        line_start = 1'b1;
        line_y     = 10'(ly);
        @(posedge clk); #1;
        line_start = 1'b0;
        busy = 0;
        while (scan_busy && busy < 200) begin
            busy++;
            if (chk_addr && busy <= 16) checkOutput("scan.oam_addr", 32'(oam_addr), 32'(busy - 1));
            @(posedge clk); #1;
        end
        if (busy >= 200) checkOutput("scan.timeout", 32'(scan_busy), 32'h0);
        modelScan(ly);
    endtask

    task automatic clearOam();
        for (int k = 0; k < 16; k++) oam_mem[k] = 32'h0;
    endtask

    typedef struct {
        int          px;
        bit          vid;
        bit          hit;
        logic [11:0] addr;
    } pix_vec_t;

    pix_vec_t t1 [7];

    initial begin
        int busy;
        vectors       = 0;
        miscompares   = 0;
        exp_rom_addr  = 12'h000;
        rom_force     = 1'b0;
        rom_force_val = 12'h000;
        reset         = 1'b1;
        line_start    = 1'b0;
        line_y        = '0;
        video_on      = 1'b0;
        x             = '0;
        clearOam();

        // Single sprite at (100,50), row 1 col 2, drawn on line 53: rom_y=11.
        t1[0] = '{103, 1'b1, 1'b1, 12'h2D3};
        t1[1] = '{108, 1'b1, 1'b0, 12'h000};
        t1[2] = '{100, 1'b1, 1'b1, 12'h2D0};
        t1[3] = '{107, 1'b1, 1'b1, 12'h2D7};
        t1[4] = '{99,  1'b1, 1'b0, 12'h000};
        t1[5] = '{104, 1'b0, 1'b0, 12'h000};
        t1[6] = '{105, 1'b1, 1'b1, 12'h2D5};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        checkOutput("reset.oam_addr",  32'(oam_addr),  32'h0);
        checkOutput("reset.rom_addr",  32'(rom_addr),  32'h0);
        checkOutput("reset.sprite_on", 32'(sprite_on), 32'h0);
        checkOutput("reset.color",     32'(color),     32'h0);
        checkOutput("reset.overflow",  32'(overflow),  32'h0);
        checkOutput("reset.scan_busy", 32'(scan_busy), 32'h0);

        // Single sprite
        oam_mem[0] = mkEntry(1'b1, 100, 50, 1, 2);
        runLine(53, 1'b1, busy);
        checkOutput("single.busy_cycles", 32'(busy), 32'd17);
        for (int i = 0; i < 7; i++)
            checkPixel("single", t1[i].px, t1[i].vid, t1[i].hit, t1[i].addr);

        // Colour key on the same line
        rom_force     = 1'b1;
        rom_force_val = 12'hF0F;
        checkPixel("key_transparent", 103, 1'b1, 1'b1, 12'h2D3);
        rom_force_val = 12'h0F0;
        checkPixel("key_opaque", 103, 1'b1, 1'b1, 12'h2D3);
        rom_force     = 1'b0;

        // Priority: entry 2 beats entry 5 at the same position
        clearOam();
        oam_mem[2] = mkEntry(1'b1, 40, 40, 3, 1);
        oam_mem[5] = mkEntry(1'b1, 40, 40, 5, 6);
        runLine(40, 1'b0, busy);
        checkPixel("prio.x40", 40, 1'b1, 1'b1, 12'h608);
        checkPixel("prio.x47", 47, 1'b1, 1'b1, 12'h60F);

        // Overflow: five sprites on line 20, entry 4 dropped
        clearOam();
        for (int k = 0; k < 5; k++) oam_mem[k] = mkEntry(1'b1, 10 + 20 * k, 20, k, k);
        runLine(20, 1'b0, busy);
        checkOutput("ovf.set", 32'(overflow), 32'h1);
        checkPixel("ovf.dropped", 90, 1'b1, 1'b0, 12'h000);
        modelCheckPixel("ovf.kept", 70, 1'b1);
        checkOutput("ovf.sticky", 32'(overflow), 32'h1);
        runLine(500, 1'b0, busy);
        checkOutput("ovf.cleared", 32'(overflow), 32'h0);

        // Edges: right screen edge and bottom-wrapping sprite
        clearOam();
        oam_mem[0] = mkEntry(1'b1, 1020, 200, 0, 0);
        oam_mem[1] = mkEntry(1'b1, 500, 1020, 1, 1);
        runLine(202, 1'b0, busy);
        checkPixel("edge.x1020", 1020, 1'b1, 1'b1, 12'h080);
        checkPixel("edge.x1023", 1023, 1'b1, 1'b1, 12'h083);
        for (int px = 0; px < 4; px++) checkPixel("edge.nowrap_x", px, 1'b1, 1'b0, 12'h000);
        runLine(2, 1'b0, busy);
        checkPixel("edge.nowrap_y", 500, 1'b1, 1'b0, 12'h000);
        runLine(1023, 1'b0, busy);
        checkPixel("edge.y1023", 500, 1'b1, 1'b1, 12'h2C8);

        // Pixels presented during a scan are ignored even once a slot is live
        clearOam();
        oam_mem[0] = mkEntry(1'b1, 100, 50, 1, 2);
        line_start = 1'b1;
        line_y     = 10'd53;
        @(posedge clk); #1;
        line_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        applyStimulus(103, 1'b1);
        @(posedge clk); #1;
        applyStimulus(0, 1'b0);
        checkOutput("busy_gate.rom_addr", 32'(rom_addr), 32'(exp_rom_addr));
        @(posedge clk);
        @(posedge clk); #1;
        checkOutput("busy_gate.sprite_on", 32'(sprite_on), 32'h0);
        busy = 0;
        while (scan_busy && busy < 200) begin
            busy++;
            @(posedge clk); #1;
        end
        checkOutput("busy_gate.scan_end", 32'(scan_busy), 32'h0);
        modelScan(53);
        modelCheckPixel("busy_gate.after", 103, 1'b1);

        // Restart at scan cycle 7 onto an empty line
        line_start = 1'b1;
        line_y     = 10'd53;
        @(posedge clk); #1;
        line_start = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        line_start = 1'b1;
        line_y     = 10'd300;
        @(posedge clk); #1;
        line_start = 1'b0;
        checkOutput("restart.oam_addr", 32'(oam_addr), 32'h0);
        checkOutput("restart.scan_busy", 32'(scan_busy), 32'h1);
        busy = 0;
        while (scan_busy && busy < 200) begin
            busy++;
            @(posedge clk); #1;
        end
        checkOutput("restart.busy_cycles", 32'(busy), 32'd17);
        modelScan(300);
        modelCheckPixel("restart.slots_cleared", 103, 1'b1);

        // Asynchronous reset at scan cycle 9
        line_start = 1'b1;
        line_y     = 10'd53;
        @(posedge clk); #1;
        line_start = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
        end
        #2 reset = 1'b1;
        #1;
        checkOutput("areset.oam_addr",  32'(oam_addr),  32'h0);
        checkOutput("areset.rom_addr",  32'(rom_addr),  32'h0);
        checkOutput("areset.sprite_on", 32'(sprite_on), 32'h0);
        checkOutput("areset.color",     32'(color),     32'h0);
        checkOutput("areset.overflow",  32'(overflow),  32'h0);
        checkOutput("areset.scan_busy", 32'(scan_busy), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_list.delete();
        model_ovf    = 1'b0;
        exp_rom_addr = 12'h000;
        checkOutput("areset.idle", 32'(scan_busy), 32'h0);
        modelCheckPixel("areset.no_slot", 103, 1'b1);

        // Randomized lines against the reference model
        for (int r = 0; r < 8; r++) begin
            int          ly;
            int          sy;
            int          px;
            int          k;
            bit          en;
            logic [31:0] w;
            ly = int'($urandom_range(0, 1023));
            for (int e = 0; e < 16; e++) begin
                en = ($urandom_range(0, 3) != 0);
                sy = (ly - int'($urandom_range(0, 12)) + 1024) % 1024;
                if ($urandom_range(0, 4) == 0) sy = int'($urandom_range(0, 1023));
                oam_mem[e] = mkEntry(en, int'($urandom_range(0, 1023)), sy,
                                     int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            end
            runLine(ly, 1'b0, busy);
            checkOutput("rand.busy_cycles", 32'(busy), 32'd17);
            checkOutput("rand.overflow", 32'(overflow), 32'(model_ovf));
            for (int p = 0; p < 10; p++) begin
                k  = int'($urandom_range(0, 15));
                w  = oam_mem[k];
                px = (int'(w[27:18]) + int'($urandom_range(0, 10)) - 1 + 1024) % 1024;
                modelCheckPixel("rand.pixel", px, ($urandom_range(0, 5) != 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
